// File: rtl/softermax_denom_acc.sv
// -----------------------------------------------------------------------------
// softermax_denom_acc
//
// Softmax denominator accumulator for the Softermax datapath. It sits directly
// after the power-of-two unit and receives one 2^(x - running_max) value per
// vector element. Each value is tagged with how far the running maximum rose
// at that element.
//
// Because every earlier term was computed against a smaller maximum, the
// partial sum must be rescaled whenever the maximum rises. The rescale factor
// is a power of two, so the running sum is updated online as
//     sum = (sum >> delta) + pow
// The first element of a vector simply seeds the sum, and its delta is ignored.
//
// When the element flagged last has been folded in, the denominator and the
// element count are registered. They are then offered to the normalization
// stage through a valid/ready handshake. The input is stalled until that
// result is taken.
//
// Optional feature (compile-time macro SOFTERMAX_SAT_EN):
//   defined   : sums that exceed 2^SUM_BW-1 clamp to all ones, and a sticky
//               overflow flag is reported on out_ovf with the result
//   undefined : the addition wraps modulo 2^SUM_BW, and out_ovf is tied to 0
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   element present on in_pow/in_delta/in_last
//   in_ready   stage accepts an element (high while accumulating)
//   in_pow     2^(x-max), unsigned Q(POW_BW-POW_FW).POW_FW
//   in_delta   amount the running max rose at this element (0 = unchanged)
//   in_last    element is the final one of its vector
//   out_valid  finished denominator available
//   out_ready  consumer accepts the denominator
//   out_sum    denominator, unsigned Q(SUM_BW-POW_FW).POW_FW
//   out_count  number of elements in the vector (wraps mod 2^CNT_BW)
//   out_ovf    accumulator saturated during the vector
// -----------------------------------------------------------------------------
module softermax_denom_acc #(
    parameter int POW_BW   = 16,
    parameter int POW_FW   = 15,
    parameter int SUM_BW   = 24,
    parameter int DELTA_BW = 5,
    parameter int CNT_BW   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [POW_BW-1:0]   in_pow,
    input  logic [DELTA_BW-1:0] in_delta,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_BW-1:0]   out_sum,
    output logic [CNT_BW-1:0]   out_count,
    output logic                out_ovf
);

    // Two-state controller: accumulate elements, or hold a finished result.
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]        state_q;

    // Running accumulation for the vector in flight.
    logic [SUM_BW-1:0] sum_q;
    logic [CNT_BW-1:0] count_q;
    logic              first_q;

    // Registered result presented to the normalization stage.
    logic [SUM_BW-1:0] out_sum_q;
    logic [CNT_BW-1:0] out_count_q;

    // Datapath for the element currently offered.
    logic [SUM_BW-1:0] pow_ext;
    logic [SUM_BW-1:0] shifted;
    logic [SUM_BW-1:0] sum_next;
    logic [CNT_BW-1:0] count_next;

    logic              in_fire;
    logic              out_fire;

`ifdef SOFTERMAX_SAT_EN
    logic              ovf_q;
    logic              out_ovf_q;
    logic [SUM_BW:0]   sum_wide;
    logic              ovf_next;
`endif

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Accumulation datapath
    // -------------------------------------------------------------------------
    // NOTE: every signal driven in always_comb is given a value on every path
    // (defaults first), so no latch can be inferred.
    always_comb begin
        // The input and the sum share POW_FW fractional bits. Zero-extension
        // therefore aligns the binary points with no shift.
        pow_ext = SUM_BW'(in_pow);

        // The first element seeds the sum, so its delta is irrelevant.
        // Shifting by the full width or more empties the sum. The explicit
        // bound keeps this behaviour independent of DELTA_BW.
        shifted = '0;
        if (!first_q && (32'(in_delta) < SUM_BW)) begin
            shifted = sum_q >> in_delta;
        end

        count_next = count_q + CNT_BW'(1);

`ifdef SOFTERMAX_SAT_EN
        // One extra bit catches the carry out of the top of the accumulator.
        sum_wide = {1'b0, shifted} + {1'b0, pow_ext};
        sum_next = sum_wide[SUM_BW] ? {SUM_BW{1'b1}} : sum_wide[SUM_BW-1:0];
        // The flag is sticky. It is seeded fresh on the first element, so a
        // stale flag cannot leak into the next vector.
        ovf_next = sum_wide[SUM_BW] || (ovf_q && !first_q);
`else
        // Plain modular addition: the carry is dropped.
        sum_next = shifted + pow_ext;
`endif
    end

    // -------------------------------------------------------------------------
    // State and result registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            sum_q       <= '0;
            count_q     <= '0;
            first_q     <= 1'b1;
            out_sum_q   <= '0;
            out_count_q <= '0;
`ifdef SOFTERMAX_SAT_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_fire) begin
                        sum_q   <= sum_next;
                        count_q <= count_next;
                        first_q <= 1'b0;
`ifdef SOFTERMAX_SAT_EN
                        ovf_q   <= ovf_next;
`endif
                        if (in_last) begin
                            // Capture the post-update values, so the final
                            // element is already included in the result.
                            out_sum_q   <= sum_next;
                            out_count_q <= count_next;
`ifdef SOFTERMAX_SAT_EN
                            out_ovf_q   <= ovf_next;
`endif
                            state_q     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // The result registers are left alone here. They keep
                    // showing the last denominator after the handshake, until
                    // the next vector completes.
                    if (out_fire) begin
                        sum_q   <= '0;
                        count_q <= '0;
                        first_q <= 1'b1;
`ifdef SOFTERMAX_SAT_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= ST_ACC;
                    end
                end

                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

`ifdef SOFTERMAX_SAT_EN
    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_softermax_denom_acc.sv
// -----------------------------------------------------------------------------
// tb_softermax_denom_acc
//
// Directed and randomized checks for softermax_denom_acc. Expected values for
// random vectors come from a plain-integer model of the denominator recurrence
// kept in this bench. Build with +define+SOFTERMAX_SAT_EN to exercise the
// saturating variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_softermax_denom_acc;

    localparam int POW_BW   = 16;
    localparam int POW_FW   = 15;
    localparam int SUM_BW   = 24;
    localparam int DELTA_BW = 5;
    localparam int CNT_BW   = 10;

`ifdef SOFTERMAX_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam longint SUM_MAX = (longint'(1) << SUM_BW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [POW_BW-1:0]   in_pow;
    logic [DELTA_BW-1:0] in_delta;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [SUM_BW-1:0]   out_sum;
    logic [CNT_BW-1:0]   out_count;
    logic                out_ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state, in plain integers.
    longint m_sum;
    int     m_cnt;
    bit     m_first;
    bit     m_ovf;

    softermax_denom_acc #(
        .POW_BW  (POW_BW),
        .POW_FW  (POW_FW),
        .SUM_BW  (SUM_BW),
        .DELTA_BW(DELTA_BW),
        .CNT_BW  (CNT_BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pow   (in_pow),
        .in_delta (in_delta),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        m_sum   = 0;
        m_cnt   = 0;
        m_first = 1'b1;
        m_ovf   = 1'b0;
    endtask

    // Denominator recurrence: the running sum is divided by 2^delta when the
    // maximum rises, then the new term is added.
    task automatic model_step(input int p, input int d);
        if (m_first) m_sum = p;
        else         m_sum = ((d >= SUM_BW) ? 0 : (m_sum / (longint'(1) << d))) + p;
        if (m_sum > SUM_MAX) begin
            if (SAT) begin
                m_sum = SUM_MAX;
                m_ovf = 1'b1;
            end else begin
                m_sum = m_sum % (SUM_MAX + 1);
            end
        end
        m_cnt   = (m_cnt + 1) % (1 << CNT_BW);
        m_first = 1'b0;
    endtask

    // Called at a falling edge. The element is accepted on the next rising
    // edge at which in_ready is high. The task returns on the falling edge
    // after acceptance, with in_valid dropped.
    task automatic push(input string tag, input int p, input int d, input bit l);
        int w;
        w = 0;
        in_pow   = POW_BW'(p);
        in_delta = DELTA_BW'(d);
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_m(input string tag, input int p, input int d, input bit l);
        model_step(p, d);
        push(tag, p, d, l);
    endtask

    // Wait (bounded) for a result, compare it, then consume it.
    task automatic collect(input string tag, input logic [31:0] es,
                           input logic [31:0] ec, input logic [31:0] eo);
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   es);
        check({tag, "_count"}, 32'(out_count), ec);
        check({tag, "_ovf"},   32'(out_ovf),   eo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [SUM_BW-1:0] held_sum;
        int                vlen;
        int                p;
        int                d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pow    = '0;
        in_delta  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);

        // Basic accumulate, including the one-cycle result latency.
        push("basic", 'h8000, 0, 1'b0);
        push("basic", 'h8000, 0, 1'b0);
        push("basic", 'h8000, 0, 1'b0);
        check("basic_valid_before_last", 32'(out_valid), 32'd0);
        push("basic", 'h8000, 0, 1'b1);
        check("basic_valid_latency", 32'(out_valid), 32'd1);
        collect("basic", 32'h020000, 32'd4, 32'd0);

        // Rescale when the running max rises.
        push("resc1", 'h8000, 0, 1'b0);
        push("resc1", 'h8000, 0, 1'b0);
        push("resc1", 'h8000, 1, 1'b1);
        collect("resc1", 32'h010000, 32'd3, 32'd0);

        push("resc24", 'h8000, 0, 1'b0);
        push("resc24", 'h8000, 0, 1'b0);
        push("resc24", 'h8000, 24, 1'b1);
        collect("resc24", 32'h008000, 32'd3, 32'd0);

        push("first_delta", 'h8000, 7, 1'b1);
        collect("first_delta", 32'h008000, 32'd1, 32'd0);

        // Back-pressure: a pending element must not be consumed in DONE.
        push("bp_prev", 'h1234, 0, 1'b1);
        held_sum = out_sum;
        in_pow   = 16'h8000;
        in_delta = '0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(out_sum),   32'h1234);
            check("bp_count",    32'(out_count), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_sum_hold", 32'(out_sum), 32'(held_sum));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect("bp_next", 32'h008000, 32'd1, 32'd0);

        // Asynchronous reset in the middle of a vector.
        push("mid", 'h8000, 0, 1'b0);
        push("mid", 'h8000, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",   32'(out_sum),   32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        push("post_rst", 'h4000, 0, 1'b0);
        push("post_rst", 'h4000, 0, 1'b1);
        collect("post_rst", 32'h008000, 32'd2, 32'd0);

        // Overflow: 512 halves reach exactly 2^SUM_BW LSBs.
        for (int i = 0; i < 513; i++) begin
            push("ovf", 'h8000, 0, (i == 512));
        end
        collect("ovf", SAT ? 32'hFFFFFF : 32'h008000, 32'd513, SAT ? 32'd1 : 32'd0);

        // The flag must not leak into the next vector.
        push("ovf_clear", 'h0100, 0, 1'b1);
        collect("ovf_clear", 32'h000100, 32'd1, 32'd0);

        // Randomized vectors against the reference model.
        for (int v = 0; v < 30; v++) begin
            model_clear();
            vlen = int'($urandom_range(1, 8));
            for (int e = 0; e < vlen; e++) begin
                p = int'($urandom_range(0, 16'hFFFF));
                d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                : int'($urandom_range(0, 2));
                push_m("rand", p, d, (e == vlen - 1));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            collect("rand", 32'(m_sum), 32'(m_cnt), 32'(m_ovf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
